// File: rtl/t07_wb_bridge.sv
// Team-07 Wishbone-classic bridge: one bus transaction per handler request,
// with a timeout guard so the handler never stalls on a dead slave.
module t07_wb_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [1:0]  rwi,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        busy_o,
  output logic [31:0] data_o,
  output logic [31:0] instr_o,
  output logic        err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  localparam logic [1:0]  RwiIdle  = 2'b00;
  localparam logic [1:0]  RwiWrite = 2'b01;
  localparam logic [1:0]  RwiRead  = 2'b10;
  localparam logic [1:0]  RwiFetch = 2'b11;
  localparam logic [31:0] Poison   = 32'hDEADBEEF;
  localparam logic [15:0] CntLast  = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  rwi_q, rwi_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] data_q, data_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        on_bus;

  always_comb begin
    state_d = state_q;
    rwi_d   = rwi_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    data_d  = data_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rwi != RwiIdle) begin
          rwi_d   = rwi;
          addr_d  = addr_i;
          wdat_d  = data_i;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack beats the timeout when both land on the same edge.
        if (wb_ack_i) begin
          if (rwi_q == RwiRead)  data_d  = wb_dat_i;
          if (rwi_q == RwiFetch) instr_d = wb_dat_i;
          state_d = DONE;
        end else if (cnt_q == CntLast) begin
          err_d = 1'b1;
          if (rwi_q == RwiRead)  data_d  = Poison;
          if (rwi_q == RwiFetch) instr_d = Poison;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      rwi_q   <= RwiIdle;
      addr_q  <= '0;
      wdat_q  <= '0;
      data_q  <= '0;
      instr_q <= Poison;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rwi_q   <= rwi_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      data_q  <= data_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Bus outputs are gated by the state flop so they idle at zero.
  assign on_bus   = (state_q == BUS);
  assign busy_o   = on_bus;
  assign wb_cyc_o = on_bus;
  assign wb_stb_o = on_bus;
  assign wb_we_o  = on_bus & (rwi_q == RwiWrite);
  assign wb_adr_o = on_bus ? addr_q : 32'h0;
  assign wb_dat_o = on_bus ? wdat_q : 32'h0;
  assign wb_sel_o = on_bus ? 4'hF : 4'h0;
  assign data_o   = data_q;
  assign instr_o  = instr_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_t07_wb_bridge.sv
// Bench for t07_wb_bridge: directed and randomized transactions checked
// against a transaction-level model of the handler-visible results.
module tb_t07_wb_bridge;

  localparam int TO = 4;
  localparam logic [31:0] POISON = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [1:0]  rwi = 2'b00;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic        busy_o;
  logic [31:0] data_o;
  logic [31:0] instr_o;
  logic        err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] data_m;
  logic [31:0] instr_m;

  t07_wb_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst), .rwi(rwi),
    .addr_i(addr_i), .data_i(data_i),
    .busy_o(busy_o), .data_o(data_o),
    .instr_o(instr_o), .err_o(err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #12;
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0 || wb_cyc_o !== 1'b0 ||
        wb_stb_o !== 1'b0 || wb_we_o !== 1'b0 || wb_sel_o !== 4'h0 ||
        wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0)
      $display("FAIL reset_ctl busy=%b err=%b cyc=%b sel=%h adr=%h want all 0",
               busy_o, err_o, wb_cyc_o, wb_sel_o, wb_adr_o);
    checks++;
    if (data_o !== 32'h0 || instr_o !== POISON) begin
      errors++;
      $display("FAIL reset_data data=%h instr=%h want 0/%h",
               data_o, instr_o, POISON);
    end
    if (busy_o !== 1'b0 || err_o !== 1'b0 || wb_cyc_o !== 1'b0 ||
        wb_stb_o !== 1'b0 || wb_we_o !== 1'b0 || wb_sel_o !== 4'h0 ||
        wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0)
      errors++;
    data_m  = 32'h0;
    instr_m = POISON;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  // One handler request; slave acks in BUS cycle nwait+1 (never if beyond TO).
  task automatic run_txn(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] d, input int nwait,
                         input logic [31:0] rdat, input bit chg,
                         input string nm);
    int k;
    bit done;
    bit exp_err;
    int exp_cyc;
    exp_err = (nwait + 1 > TO);
    exp_cyc = exp_err ? TO : nwait + 1;
    @(negedge clk);
    rwi = op; addr_i = a; data_i = d;
    @(posedge clk); #1;
    rwi = 2'b00;
    k = 0;
    done = 1'b0;
    while (!done && k < 20) begin
      k++;
      wb_ack_i = (k == nwait + 1);
      wb_dat_i = (k == nwait + 1) ? rdat : $urandom;
      if (chg) begin
        addr_i = $urandom;
        data_i = $urandom;
      end
      @(negedge clk);
      checks++;
      if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL %s bus_ctl cyc=%b stb=%b busy=%b want 1", nm,
                 wb_cyc_o, wb_stb_o, busy_o);
      end
      checks++;
      if (wb_adr_o !== a || wb_dat_o !== d) begin
        errors++;
        $display("FAIL %s bus_adr adr=%h dat=%h want %h/%h", nm,
                 wb_adr_o, wb_dat_o, a, d);
      end
      checks++;
      if (wb_we_o !== (op == 2'b01) || wb_sel_o !== 4'hF) begin
        errors++;
        $display("FAIL %s bus_we_sel we=%b sel=%h want %b/F", nm,
                 wb_we_o, wb_sel_o, op == 2'b01);
      end
      @(posedge clk); #1;
      wb_ack_i = 1'b0;
      if (busy_o === 1'b0) done = 1'b1;
    end
    checks++;
    if (!done || k != exp_cyc) begin
      errors++;
      $display("FAIL %s busy_len got %0d want %0d", nm, k, exp_cyc);
    end
    if (op == 2'b10) data_m  = exp_err ? POISON : rdat;
    if (op == 2'b11) instr_m = exp_err ? POISON : rdat;
    @(negedge clk);
    checks++;
    if (data_o !== data_m || instr_o !== instr_m) begin
      errors++;
      $display("FAIL %s result data=%h instr=%h want %h/%h", nm,
               data_o, instr_o, data_m, instr_m);
    end
    checks++;
    if (err_o !== exp_err) begin
      errors++;
      $display("FAIL %s err_done got %b want %b", nm, err_o, exp_err);
    end
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0 ||
        wb_sel_o !== 4'h0 || wb_we_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s done_idle cyc=%b adr=%h sel=%h busy=%b want 0", nm,
               wb_cyc_o, wb_adr_o, wb_sel_o, busy_o);
    end
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done err=%b busy=%b want 0/0", nm, err_o, busy_o);
    end
  endtask

  task automatic test_fetch_zero_wait();
    run_txn(2'b11, 32'h100, 32'h0, 0, 32'h00500093, 1'b0, "fetch0");
  endtask

  task automatic test_read_wait3();
    run_txn(2'b10, 32'h2000, 32'h0, 3, 32'hCAFEF00D, 1'b0, "read3");
  endtask

  task automatic test_write_change();
    run_txn(2'b01, 32'h3004, 32'h12345678, 1, 32'h5555AAAA, 1'b1, "write");
  endtask

  task automatic test_timeout();
    run_txn(2'b10, 32'h40, 32'h0, 100, 32'h0, 1'b0, "timeout");
    run_txn(2'b11, 32'h44, 32'h0, 100, 32'h0, 1'b0, "timeout_f");
  endtask

  task automatic test_ack_on_timeout();
    run_txn(2'b10, 32'h48, 32'h0, TO - 1, 32'h1, 1'b0, "ack_edge");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(1, 3));
      run_txn(op, $urandom, $urandom, $urandom_range(0, 5), $urandom,
              1'($urandom), "rand");
    end
  endtask

  task automatic test_ack_outside();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      wb_ack_i = 1'b1;
      wb_dat_i = $urandom;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || data_o !== data_m || instr_o !== instr_m) begin
        errors++;
        $display("FAIL ack_outside busy=%b data=%h instr=%h want 0/%h/%h",
                 busy_o, data_o, instr_o, data_m, instr_m);
      end
    end
    wb_ack_i = 1'b0;
  endtask

  task automatic test_held();
    int rises[$];
    logic prev;
    logic [31:0] last;
    prev = 1'b0;
    last = '0;
    @(negedge clk);
    rwi = 2'b10;
    addr_i = 32'h500;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (wb_cyc_o === 1'b1) begin
        wb_ack_i = 1'b1;
        last = $urandom;
        wb_dat_i = last;
      end else begin
        wb_ack_i = 1'b0;
      end
      @(negedge clk);
      if (busy_o === 1'b1 && prev === 1'b0) rises.push_back(i);
      prev = busy_o;
    end
    rwi = 2'b00;
    @(posedge clk); #1;
    wb_ack_i = 1'b0;
    data_m = last;
    checks++;
    if (rises.size() != 4) begin
      errors++;
      $display("FAIL held_count starts=%0d want 4", rises.size());
    end
    for (int i = 1; i < rises.size(); i++) begin
      checks++;
      if (rises[i] - rises[i-1] != 3) begin
        errors++;
        $display("FAIL held_period gap=%0d want 3", rises[i] - rises[i-1]);
      end
    end
    @(negedge clk);
    checks++;
    if (data_o !== data_m || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL held_data data=%h busy=%b want %h/0",
               data_o, busy_o, data_m);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    rwi = 2'b11;
    addr_i = 32'h900;
    @(posedge clk); #1;
    rwi = 2'b00;
    wb_ack_i = 1'b0;
    #2;
    checks++;
    if (wb_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pre cyc=%b want 1", wb_cyc_o);
    end
    nrst = 1'b0;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy_o !== 1'b0 ||
        wb_adr_o !== 32'h0 || wb_sel_o !== 4'h0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_bus cyc=%b stb=%b busy=%b adr=%h want 0",
               wb_cyc_o, wb_stb_o, busy_o, wb_adr_o);
    end
    checks++;
    if (instr_o !== POISON || data_o !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_data instr=%h data=%h want %h/0",
               instr_o, data_o, POISON);
    end
    data_m  = 32'h0;
    instr_m = POISON;
    @(negedge clk);
    nrst = 1'b1;
    run_txn(2'b10, 32'h904, 32'h0, 0, 32'h77, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_fetch_zero_wait();
    test_read_wait3();
    test_write_change();
    test_timeout();
    test_ack_on_timeout();
    test_random();
    test_ack_outside();
    test_held();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
